lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/eka_pkg.sv | 31 +++
 rtl/lsu_load_align.sv | 37 +++
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eka_pkg.sv
// Shared definitions for the load/store unit.
// - funct3 width/sign codes used by loads and stores
// - lsu_state_t: access sequencer states
// - is_misaligned(): natural-alignment test for a given width code
package eka_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_t;

  // Bytes are always aligned; halfwords need an even address; words (and any
  // code not naming a byte or halfword) need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load extraction and extension (purely combinational).
// Ports:
//   rdata_i    : 32-bit word returned by data memory
//   byte_off_i : byte offset of the access within the word (addr[1:0])
//   funct3_i   : load width/sign code
//   data_o     : selected byte/half/word, sign- or zero-extended to 32 bits
module lsu_load_align
  import eka_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[byte_off_i];
    // Halfwords are known to be aligned here, so only bit 1 picks the half.
    half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'b0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one load or store into a single request/grant
// transaction on a word-addressed data memory port.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle launch pulse, only honoured while idle
//   mem_read/mem_write  : access kind (exactly one must be set)
//   funct3, addr        : width/sign code and byte address
//   store_data          : unshifted store value
//   busy, done          : access in progress / one-cycle completion pulse
//   load_data           : extended load result, held between completions
//   misaligned          : with done, the access was rejected for alignment
//   dmem_*              : memory port (req/gnt handshake, rvalid read return)
module lsu
  import eka_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_t      state_q;
  logic            busy_q, done_q, mis_q;
  logic            req_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
  logic [3:0]      be_q;
  logic            is_load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;

  logic [3:0]      st_be_d;
  logic [XLEN-1:0] st_wdata_d;
  logic            mis_d;
  logic [XLEN-1:0] align_data;

  // Store lane steering: byte/half data is replicated on every lane so the
  // byte enables alone pick which bytes memory actually writes.
  always_comb begin
    mis_d = is_misaligned(funct3, addr[1:0]);
    case (funct3)
      F3_LB: begin
        st_be_d    = 4'b0001 << addr[1:0];
        st_wdata_d = {4{store_data[7:0]}};
      end
      F3_LH: begin
        st_be_d    = 4'b0011 << addr[1:0];
        st_wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        st_be_d    = 4'b1111;
        st_wdata_d = store_data;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .rdata_i    (dmem_rdata),
    .byte_off_i (off_q),
    .funct3_i   (funct3_q),
    .data_o     (align_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      is_load_q   <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Both or neither of mem_read/mem_write is not a valid access.
          if (start && (mem_read ^ mem_write)) begin
            is_load_q <= mem_read;
            funct3_q  <= funct3;
            off_q     <= addr[1:0];
            busy_q    <= 1'b1;
            if (mis_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= mem_write;
              addr_q  <= {addr[XLEN-1:2], 2'b00};
              be_q    <= mem_read ? 4'b1111 : st_be_d;
              wdata_q <= mem_read ? '0 : st_wdata_d;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (is_load_q) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // Read data is only taken here, never in the grant cycle.
          if (dmem_rvalid) begin
            load_data_q <= align_data;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign load_data  = load_data_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset, start, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, misaligned, dmem_req, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_ld = 32'h0;   // what load_data should currently hold

  lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (from the access rules) ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input bit is_load, input logic [2:0] f3,
                                          input logic [31:0] a);
    int mask;
    if (is_load) return 4'hF;
    mask = (1 << size_of(f3)) - 1;
    return 4'((mask << int'(a[1:0])) & 15);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = size_of(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = size_of(f3);
    logic [31:0] v;
    if (sz == 4) return rd;
    v = rd >> (8 * int'(a[1:0]));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3[2] == 1'b0 && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = v & 32'hFFFF;
      if (f3[2] == 1'b0 && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- access driver: stimulus + observation only -------------
  // Returns done_cyc = cycles from the start edge to the done pulse (-1 on
  // timeout), request count, first request fields and several sticky flags.
  task automatic do_access(input bit is_load, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int gnt_wait, input int rv_wait, input bit rv_with_gnt,
                           output int done_cyc, output int reqs,
                           output logic [3:0] be_o, output logic [31:0] addr_o,
                           output logic [31:0] wdata_o, output logic we_o,
                           output bit unstable, output bit busy_low,
                           output logic mis_o, output logic [31:0] ld_o,
                           output logic done_after, output logic busy_after);
    bit granted = 0, rv_sent = 0;
    int since = 0;
    done_cyc = -1; reqs = 0; unstable = 0; busy_low = 0;
    be_o = 'x; addr_o = 'x; wdata_o = 'x; we_o = 'x; mis_o = 'x; ld_o = 'x;
    start = 1'b1; mem_read = is_load; mem_write = !is_load;
    funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
    for (int c = 1; c <= 60; c++) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (done) begin
        done_cyc = c; mis_o = misaligned; ld_o = load_data;
        break;
      end
      if (!busy) busy_low = 1;
      if (dmem_req) begin
        if (reqs == 0) begin
          be_o = dmem_be; addr_o = dmem_addr; wdata_o = dmem_wdata; we_o = dmem_we;
        end else if (dmem_be !== be_o || dmem_addr !== addr_o ||
                     dmem_wdata !== wdata_o || dmem_we !== we_o) begin
          unstable = 1;
        end
        reqs++;
        if (reqs > gnt_wait) begin
          dmem_gnt = 1'b1; granted = 1;
          if (rv_with_gnt) begin dmem_rvalid = 1'b1; dmem_rdata = ~rd; end
        end
      end else if (granted && is_load && !rv_sent) begin
        if (since >= rv_wait) begin dmem_rvalid = 1'b1; dmem_rdata = rd; rv_sent = 1; end
        since++;
      end
      @(posedge clk); #1;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    done_after = done; busy_after = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    addr = 32'h100; store_data = 32'h1234; dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, misaligned, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b mis=%b req=%b we=%b be=%h addr=%h wdata=%h ld=%h required all zero",
               busy, done, misaligned, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data);
    end
    reset = 1'b0; start = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    model_ld = 32'h0;
    $display("txn reset done");
  endtask

  task automatic test_directed();
    int dc, rq; logic [3:0] be; logic [31:0] ad, wd, ld; logic we, mis, da, ba; bit us, bl;
    // Word store, grant after two wait cycles.
    do_access(0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0, 0, dc, rq, be, ad, wd, we, us, bl, mis, ld, da, ba);
    $display("txn SW addr=00000100 be=%b dmem_addr=%h wdata=%h done_cyc=%0d", be, ad, wd, dc);
    checks++;
    if (be !== 4'b1111 || ad !== 32'h100 || wd !== 32'hDEADBEEF || we !== 1'b1) begin
      failures++;
      $display("FAIL sw_fields: got be=%b addr=%h wdata=%h we=%b required 1111/00000100/deadbeef/1", be, ad, wd, we);
    end
    checks++;
    if (dc != 4 || rq != 3 || da !== 1'b0) begin
      failures++;
      $display("FAIL sw_timing: got done_cyc=%0d reqs=%0d done_next=%b required 4/3/0", dc, rq, da);
    end
    // Byte store at the top lane.
    do_access(0, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 0, dc, rq, be, ad, wd, we, us, bl, mis, ld, da, ba);
    $display("txn SB addr=00000103 be=%b dmem_addr=%h wdata=%h done_cyc=%0d", be, ad, wd, dc);
    checks++;
    if (be !== 4'b1000 || ad !== 32'h100 || wd !== 32'hA5A5A5A5 || dc != 2) begin
      failures++;
      $display("FAIL sb_fields: got be=%b addr=%h wdata=%h done_cyc=%0d required 1000/00000100/a5a5a5a5/2", be, ad, wd, dc);
    end
    // Loads from the same word with different widths/signedness.
    begin
      logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
      logic [31:0] exps[5] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'h00000080, 32'h0080FF00};
      for (int i = 0; i < 5; i++) begin
        do_access(1, f3s[i], 32'h102 & ((f3s[i] == 3'b010) ? 32'hFFFFFFFC : 32'hFFFFFFFF),
                  32'h0, 32'h0080FF00, i % 2, i % 3, 0, dc, rq, be, ad, wd, we, us, bl, mis, ld, da, ba);
        model_ld = exps[i];
        $display("txn LOAD f3=%b load_data=%h done_cyc=%0d", f3s[i], ld, dc);
        checks++;
        if (ld !== exps[i] || load_data !== exps[i] || be !== 4'b1111 || we !== 1'b0 || ad !== 32'h100) begin
          failures++;
          $display("FAIL load_f3_%b: got ld=%h be=%b we=%b addr=%h required ld=%h be=1111 we=0 addr=00000100",
                   f3s[i], ld, be, we, ad, exps[i]);
        end
        checks++;
        if (dc != 3 + (i % 2) + (i % 3)) begin
          failures++;
          $display("FAIL load_latency_%0d: got %0d required %0d", i, dc, 3 + (i % 2) + (i % 3));
        end
      end
    end
    // Misaligned halfword load: rejected with no memory request.
    do_access(1, 3'b001, 32'h101, 32'h0, 32'h12345678, 0, 0, 0, dc, rq, be, ad, wd, we, us, bl, mis, ld, da, ba);
    $display("txn LH addr=00000101 reqs=%0d mis=%b done_cyc=%0d load_data=%h", rq, mis, dc, ld);
    checks++;
    if (rq != 0 || mis !== 1'b1 || dc < 1 || dc > 2 || ld !== model_ld || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL lh_misaligned: got reqs=%0d mis=%b done_cyc=%0d ld=%h mis_after=%b required 0/1/1..2/%h/0",
               rq, mis, dc, ld, misaligned, model_ld);
    end
    // rvalid coincident with grant carries wrong data and must be dropped.
    do_access(1, 3'b010, 32'h2000, 32'h0, 32'hCAFEF00D, 1, 1, 1, dc, rq, be, ad, wd, we, us, bl, mis, ld, da, ba);
    model_ld = 32'hCAFEF00D;
    $display("txn LW rvalid-with-gnt load_data=%h", ld);
    checks++;
    if (ld !== 32'hCAFEF00D || dc != 5) begin
      failures++;
      $display("FAIL rvalid_with_gnt: got ld=%h done_cyc=%0d required cafef00d/5", ld, dc);
    end
  endtask

  task automatic test_random(input int n);
    int dc, rq, gw, rw, exp_dc; logic [3:0] be; logic [31:0] ad, wd, ld, a, sd, rd;
    logic we, mis, da, ba; bit us, bl, is_load, emis; logic [2:0] f3;
    logic [2:0] ld_codes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int t = 0; t < n; t++) begin
      is_load = 1'($urandom_range(0, 1));
      f3 = is_load ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom; sd = $urandom; rd = $urandom;
      gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      do_access(is_load, f3, a, sd, rd, gw, rw, 1'($urandom_range(0, 1)),
                dc, rq, be, ad, wd, we, us, bl, mis, ld, da, ba);
      emis = model_mis(f3, a);
      if (is_load && !emis) model_ld = model_load(f3, a, rd);
      exp_dc = emis ? 1 : (is_load ? 3 + gw + rw : 2 + gw);
      $display("txn %0d %s f3=%b addr=%h done_cyc=%0d mis=%b be=%b wdata=%h ld=%h",
               t, is_load ? "LD" : "ST", f3, a, dc, mis, be, wd, ld);
      checks++;
      if (emis ? (dc < 1 || dc > 2) : (dc != exp_dc)) begin
        failures++;
        $display("FAIL rnd%0d_latency: got %0d required %0d", t, dc, exp_dc);
      end
      checks++;
      if (mis !== emis || rq != (emis ? 0 : gw + 1)) begin
        failures++;
        $display("FAIL rnd%0d_misaligned: got mis=%b reqs=%0d required mis=%b reqs=%0d",
                 t, mis, rq, emis, emis ? 0 : gw + 1);
      end
      if (!emis) begin
        checks++;
        if (be !== model_be(is_load, f3, a) || ad !== {a[31:2], 2'b00} || we !== !is_load ||
            (!is_load && wd !== model_wdata(f3, sd)) || us) begin
          failures++;
          $display("FAIL rnd%0d_request: got be=%b addr=%h we=%b wdata=%h unstable=%b required be=%b addr=%h we=%b wdata=%h",
                   t, be, ad, we, wd, us, model_be(is_load, f3, a), {a[31:2], 2'b00}, !is_load, model_wdata(f3, sd));
        end
      end
      checks++;
      if (ld !== model_ld) begin
        failures++;
        $display("FAIL rnd%0d_load_data: got %h required %h", t, ld, model_ld);
      end
      checks++;
      if (bl || da !== 1'b0 || ba !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_busy_done: got busy_dropped=%b done_next=%b busy_next=%b required 0/0/0", t, bl, da, ba);
      end
    end
  endtask

  task automatic test_ignored();
    int req_cycles, dones, activity;
    bit addr_bad;
    // Both and neither op bits set.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; mem_read = (k == 0); mem_write = (k == 0);
      funct3 = 3'b010; addr = 32'h300;
      @(posedge clk); #1;
      start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      activity = 0;
      for (int c = 0; c < 4; c++) begin
        if (dmem_req || busy || done) activity++;
        @(posedge clk); #1;
      end
      $display("txn bad-op start k=%0d activity=%0d", k, activity);
      checks++;
      if (activity != 0) begin
        failures++;
        $display("FAIL bad_op_%0d: got %0d active cycles required 0", k, activity);
      end
    end
    // Start pulses in REQ and in DONE must not launch new accesses.
    start = 1'b1; mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'b010;
    addr = 32'h40; store_data = 32'h11223344;
    @(posedge clk); #1;
    req_cycles = 0; dones = 0; addr_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_gnt = (c == 4);
      if (dmem_req) begin
        req_cycles++;
        if (dmem_addr !== 32'h40) addr_bad = 1;
      end
      if (done) dones++;
      if (c == 1 || c == 5) begin
        start = 1'b1; mem_read = 1'b1; addr = 32'h80; funct3 = 3'b010;
      end
      @(posedge clk); #1;
    end
    dmem_gnt = 1'b0; start = 1'b0; mem_read = 1'b0;
    $display("txn start-while-busy req_cycles=%0d dones=%0d", req_cycles, dones);
    checks++;
    if (req_cycles != 4 || dones != 1 || addr_bad) begin
      failures++;
      $display("FAIL start_while_busy: got req_cycles=%0d dones=%0d addr_bad=%b required 4/1/0", req_cycles, dones, addr_bad);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0, busies = 0, waited = 0;
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1;
    start = 1'b0; mem_read = 1'b0;
    while (!dmem_req && waited < 10) begin @(posedge clk); #1; waited++; end
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    reset = 1'b1;                 // now in WAIT
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      if (busy) busies++;
      @(posedge clk); #1;
    end
    model_ld = 32'h0;
    $display("txn reset-in-wait waited=%0d dones=%0d busies=%0d ld=%h", waited, dones, busies, load_data);
    checks++;
    if (waited >= 10 || dones != 0 || busies != 0 || load_data !== model_ld || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_access: got waited=%0d dones=%0d busies=%0d ld=%h req=%b required <10/0/0/00000000/0",
               waited, dones, busies, load_data, dmem_req);
    end
  endtask

  initial begin
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0;
    store_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; reset = 1'b1;
    test_reset();
    test_directed();
    test_random(40);
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
